// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I data-memory access stage. Runs one load or store per
//               request over a req/ack bus. Loads return an aligned, sign- or
//               zero-extended result. Faults and bus timeouts are reported
//               through a 2-bit error code.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  err_o,
   output logic [31:0] load_data_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_MISALGN = 2'b01;
   localparam logic [1:0] ERR_FUNCT3  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // Last counter value before the abort fires; counter starts at 0 on issue.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] ld_q, ld_d;

   logic        illegal;
   logic        misaligned;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic [31:0] lane;
   logic [31:0] load_ext;

   // Request decode: funct3 legality, alignment, byte enables and lane data.
   always_comb begin
      illegal    = (funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                   (funct3_i == 3'b111) || (is_store_i && funct3_i[2]);
      misaligned = 1'b0;
      be_calc    = 4'b1111;
      wdata_calc = store_data_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << addr_i[1:0];
            wdata_calc = {4{store_data_i[7:0]}};
         end
         2'b01: begin
            misaligned = addr_i[0];
            be_calc    = 4'b0011 << addr_i[1:0];
            wdata_calc = {2{store_data_i[15:0]}};
         end
         default: begin
            misaligned = (addr_i[1:0] != 2'b00);
         end
      endcase
   end

   // Shift the addressed bytes down to bit 0, then extend per funct3.
   always_comb begin
      lane = mem_rdata_i >> {addr_q[1:0], 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   // Next-state logic: accept/fault in IDLE, wait for ack or timeout in ISSUE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      err_d   = err_q;
      ld_d    = ld_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               ld_d = 32'd0;
               if (illegal) begin
                  state_d = S_DONE;
                  err_d   = ERR_FUNCT3;
               end else if (misaligned) begin
                  state_d = S_DONE;
                  err_d   = ERR_MISALGN;
               end else begin
                  state_d = S_ISSUE;
                  err_d   = ERR_OK;
                  addr_d  = addr_i;
                  we_d    = is_store_i;
                  be_d    = be_calc;
                  wdata_d = wdata_calc;
                  f3_d    = funct3_i;
                  cnt_d   = 8'd0;
               end
            end
         end
         S_ISSUE: begin
            // An ack on the final allowed cycle still completes normally.
            if (mem_ack_i) begin
               state_d = S_DONE;
               err_d   = ERR_OK;
               ld_d    = we_q ? 32'd0 : load_ext;
            end else if (cnt_q == TMO_LAST) begin
               state_d = S_DONE;
               err_d   = ERR_TIMEOUT;
               ld_d    = 32'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= 32'd0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         err_q   <= ERR_OK;
         ld_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         err_q   <= err_d;
         ld_q    <= ld_d;
      end
   end

   // Outputs decode only from registers; the bus is forced to zero outside ISSUE.
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
   assign err_o       = err_q;
   assign load_data_o = ld_q;
   assign mem_req_o   = (state_q == S_ISSUE);
   assign mem_we_o    = mem_req_o & we_q;
   assign mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be_o    = mem_req_o ? be_q : 4'd0;
   assign mem_wdata_o = mem_req_o ? wdata_q : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed cases plus
//               randomized transactions against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        busy, done;
   logic [1:0]  err;
   logic [31:0] load_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ack = 1'b0;

   int n_total = 0;
   int n_bad   = 0;

   load_store_unit #(.TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .is_store_i   (is_store),
      .funct3_i     (funct3),
      .addr_i       (addr),
      .store_data_i (store_data),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .load_data_o  (load_data),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_be_o     (mem_be),
      .mem_wdata_o  (mem_wdata),
      .mem_rdata_i  (mem_rdata),
      .mem_ack_i    (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One transaction. ack_at = ISSUE cycle (1-based) that sees mem_ack, 0 = never.
   task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int ack_at);
      int          nb;
      int          off;
      bit          acked;
      logic [1:0]  e_err;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_ld;
      longint      v;

      // Reference model: sizes in bytes, lanes built byte by byte.
      nb    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off   = int'(a[1:0]);
      e_err = 2'b00;
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (st && f3[2]))
         e_err = 2'b10;
      else if ((a % nb) != 0)
         e_err = 2'b01;
      e_be = 4'd0;
      e_wd = 32'd0;
      v    = 0;
      if (e_err == 2'b00) begin
         for (int i = 0; i < nb; i++) e_be[off + i] = 1'b1;
         for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = sd[8*(i % nb) +: 8];
         for (int i = 0; i < nb; i++) v = v | (longint'(rd[8*(off + i) +: 8]) << (8*i));
         if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
      end

      // Cycle 0: present the request; a stray ack here must be ignored.
      @(posedge clk); #1;
      start      = 1'b1;
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      mem_ack    = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(posedge clk); #1;
      start   = 1'b0;
      mem_ack = 1'b0;

      if (e_err != 2'b00) begin
         e_ld = 32'd0;
         check("fault_req", {31'd0, mem_req}, 32'd0);
         check("fault_done", {31'd0, done}, 32'd1);
         check("fault_err", {30'd0, err}, {30'd0, e_err});
         check("fault_ld", load_data, e_ld);
      end else begin
         acked = 1'b0;
         for (int k = 1; k <= TMO && !acked; k++) begin
            check("issue_req", {31'd0, mem_req}, 32'd1);
            check("issue_done", {31'd0, done}, 32'd0);
            check("issue_busy", {31'd0, busy}, 32'd1);
            check("issue_we", {31'd0, mem_we}, {31'd0, st});
            check("issue_addr", mem_addr, {a[31:2], 2'b00});
            check("issue_be", {28'd0, mem_be}, {28'd0, e_be});
            check("issue_wdata", mem_wdata, e_wd);
            // Noise on request inputs while busy must not disturb the bus.
            start      = 1'($urandom_range(0, 1));
            is_store   = 1'($urandom_range(0, 1));
            funct3     = 3'($urandom_range(0, 7));
            addr       = $urandom;
            store_data = $urandom;
            mem_ack    = (k == ack_at);
            mem_rdata  = (k == ack_at) ? rd : $urandom;
            if (k == ack_at) acked = 1'b1;
            @(posedge clk); #1;
         end
         if (acked) begin
            e_err = 2'b00;
            e_ld  = st ? 32'd0 : v[31:0];
         end else begin
            e_err = 2'b11;
            e_ld  = 32'd0;
         end
         check("done_pulse", {31'd0, done}, 32'd1);
         check("done_err", {30'd0, err}, {30'd0, e_err});
         check("done_ld", load_data, e_ld);
         check("done_req_off", {31'd0, mem_req}, 32'd0);
         check("done_bus_zero", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
      end

      // DONE cycle: start and ack here are ignored.
      start   = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      start   = 1'b0;
      mem_ack = 1'b0;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
      check("hold_err", {30'd0, err}, {30'd0, e_err});
      check("hold_ld", load_data, e_ld);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {30'd0, err}, 32'd0);
      check("rst_ld", load_data, 32'd0);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_bus", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);

      // Directed cases
      run_txn(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1);
      run_txn(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1);
      run_txn(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_0000, 2);
      run_txn(1'b1, 3'b001, 32'h0000_0206, 32'h1234_ABCD, 32'd0, 4);
      run_txn(1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 1);
      run_txn(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 1);
      run_txn(1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 1);
      run_txn(1'b0, 3'b001, 32'h0000_0203, 32'd0, 32'h8765_4321, 1);
      run_txn(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h1111_2222, 0);
      run_txn(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h3333_4444, TMO);
      run_txn(1'b0, 3'b001, 32'h0000_0402, 32'd0, 32'h9ABC_0000, 3);
      run_txn(1'b0, 3'b101, 32'h0000_0402, 32'd0, 32'h9ABC_0000, 3);

      // Reset in the second ISSUE cycle aborts silently.
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0500;
      @(posedge clk); #1;
      start = 1'b0;
      check("mid_req1", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_req_drop", {31'd0, mem_req}, 32'd0);
      check("mid_busy", {31'd0, busy}, 32'd0);
      check("mid_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      check("mid_no_done", {31'd0, done}, 32'd0);
      run_txn(1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'hCAFE_F00D, 1);

      // Randomized transactions
      for (int t = 0; t < 200; t++) begin
         logic [2:0]  rf3;
         logic [31:0] ra;
         int          ack;
         rf3 = 3'($urandom_range(0, 7));
         ra  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (rf3[1:0] == 2'b10) ra[1:0] = 2'b00;
            else if (rf3[1:0] == 2'b01) ra[0] = 1'b0;
         end
         ack = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
         run_txn(1'($urandom_range(0, 1)), rf3, ra, $urandom, $urandom, ack);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
